// File: rtl/alu_serial_responder_if.sv
// Serial pin bundle between the ALU command BFM (master) and the responder (slave).
// Clock and reset travel as plain ports beside this interface.
interface alu_serial_if;
    logic enable_n;
    logic din;
    logic dout;
    logic dout_valid;
    logic busy;

    modport master (
        output enable_n,
        output din,
        input  dout,
        input  dout_valid,
        input  busy
    );

    modport slave (
        input  enable_n,
        input  din,
        output dout,
        output dout_valid,
        output busy
    );
endinterface

// File: rtl/alu_serial_responder.sv
// DUT-side endpoint of the ALU serial protocol: receives A, B and opcode frames,
// runs the 8-bit ALU operation and shifts back a status/MSB/LSB response.
module alu_serial_responder #(
    parameter int RESP_GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_serial_if.slave  bus
);

    localparam logic [3:0] GAP_LAST   = 4'(RESP_GAP - 1);
    localparam logic [4:0] RX_LAST    = 5'd29;
    localparam logic [4:0] TX_BITS    = 5'd30;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        EXEC,
        GAP,
        TX
    } state_t;

    state_t      state_reg;
    logic [29:0] rx_shift_reg;
    logic [4:0]  rx_cnt_reg;
    logic [29:0] tx_shift_reg;
    logic [4:0]  tx_cnt_reg;
    logic [3:0]  gap_cnt_reg;
    logic        dout_reg;
    logic        dout_valid_reg;
    logic        busy_reg;

    assign bus.dout       = dout_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.busy       = busy_reg;

    // Frame 0 (A) arrives first, so it ends up in the top ten bits of the shifter.
    logic [9:0] frame [3];
    logic [2:0] par_err;
    logic [2:0] type_bit;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_frame
            assign frame[gi]    = rx_shift_reg[29 - 10*gi -: 10];
            assign par_err[gi]  = ^frame[gi];
            assign type_bit[gi] = frame[gi][9];
        end
    endgenerate

    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic [7:0]  op_val;
    logic [15:0] a_sext;
    logic [15:0] b_sext;
    logic [8:0]  add9;

    assign a_val  = frame[0][8:1];
    assign b_val  = frame[1][8:1];
    assign op_val = frame[2][8:1];
    assign a_sext = {{8{a_val[7]}}, a_val};
    assign b_sext = {{8{b_val[7]}}, b_val};
    assign add9   = {1'b0, a_val} + {1'b0, b_val};

    function automatic logic [9:0] mk_frame(input logic ftype, input logic [7:0] data);
        return {ftype, data, ^{ftype, data}};
    endfunction

    logic [15:0] alu_result;
    logic [15:0] resp_result;
    logic [7:0]  resp_status;
    logic        carry_flag;
    logic        ovf_flag;
    logic        inv_op;
    logic        perr_any;
    logic        ferr_any;
    logic [29:0] resp_word;

    always_comb begin
        alu_result  = 16'h0000;
        carry_flag  = 1'b0;
        ovf_flag    = 1'b0;
        inv_op      = 1'b0;
        case (op_val)
            8'h01: begin
                alu_result = a_sext + b_sext;
                carry_flag = add9[8];
                ovf_flag   = (a_val[7] == b_val[7]) && (alu_result[7] != a_val[7]);
            end
            8'h02: alu_result = {8'h00, a_val & b_val};
            8'h03: alu_result = {8'h00, a_val | b_val};
            8'h04: alu_result = {8'h00, a_val ^ b_val};
            8'h05: begin
                alu_result = a_sext - b_sext;
                carry_flag = (a_val < b_val);
                ovf_flag   = (a_val[7] != b_val[7]) && (alu_result[7] != a_val[7]);
            end
            // Low 16 bits of the product match for signed and unsigned operands.
            8'h06: alu_result = a_sext * b_sext;
            default: inv_op = 1'b1;
        endcase

        perr_any = |par_err;
        ferr_any = type_bit[0] | type_bit[1] | ~type_bit[2];

        if (perr_any || ferr_any || inv_op) begin
            resp_result = 16'h0000;
            resp_status = {1'b0, inv_op, ferr_any, perr_any, 4'b0000};
        end else begin
            resp_result = alu_result;
            resp_status = {4'b0000, alu_result[15], (alu_result == 16'h0000),
                           ovf_flag, carry_flag};
        end

        resp_word = {mk_frame(1'b1, resp_status),
                     mk_frame(1'b0, resp_result[15:8]),
                     mk_frame(1'b0, resp_result[7:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rx_shift_reg   <= '0;
            rx_cnt_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_cnt_reg     <= '0;
            gap_cnt_reg    <= '0;
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!bus.enable_n) begin
                        rx_shift_reg <= {29'b0, bus.din};
                        rx_cnt_reg   <= 5'd1;
                        state_reg    <= RX;
                    end
                end

                RX: begin
                    if (bus.enable_n) begin
                        rx_shift_reg <= '0;
                        rx_cnt_reg   <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        rx_shift_reg <= {rx_shift_reg[28:0], bus.din};
                        if (rx_cnt_reg == RX_LAST) begin
                            rx_cnt_reg <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= EXEC;
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 5'd1;
                        end
                    end
                end

                // Response is latched here; with no gap its first bit goes out on this edge.
                EXEC: begin
                    if (RESP_GAP == 0) begin
                        dout_reg       <= resp_word[29];
                        tx_shift_reg   <= {resp_word[28:0], 1'b0};
                        dout_valid_reg <= 1'b1;
                        tx_cnt_reg     <= 5'd1;
                        state_reg      <= TX;
                    end else begin
                        tx_shift_reg <= resp_word;
                        gap_cnt_reg  <= '0;
                        state_reg    <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        dout_reg       <= tx_shift_reg[29];
                        tx_shift_reg   <= {tx_shift_reg[28:0], 1'b0};
                        dout_valid_reg <= 1'b1;
                        tx_cnt_reg     <= 5'd1;
                        state_reg      <= TX;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end

                TX: begin
                    if (tx_cnt_reg == TX_BITS) begin
                        dout_reg       <= 1'b0;
                        dout_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        tx_cnt_reg     <= '0;
                        state_reg      <= IDLE;
                    end else begin
                        dout_reg     <= tx_shift_reg[29];
                        tx_shift_reg <= {tx_shift_reg[28:0], 1'b0};
                        tx_cnt_reg   <= tx_cnt_reg + 5'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Bench for alu_serial_responder: three instances (gap 0, 1, 15) share one command
// stream; responses are compared with an integer-arithmetic reference model.
module tb_alu_serial_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en_n;
    logic din_b;

    alu_serial_if bus_g0 ();
    alu_serial_if bus_g1 ();
    alu_serial_if bus_g15 ();

    assign bus_g0.enable_n  = en_n;
    assign bus_g1.enable_n  = en_n;
    assign bus_g15.enable_n = en_n;
    assign bus_g0.din       = din_b;
    assign bus_g1.din       = din_b;
    assign bus_g15.din      = din_b;

    logic [2:0] dv_w;
    logic [2:0] do_w;
    logic [2:0] busy_w;
    assign dv_w   = {bus_g15.dout_valid, bus_g1.dout_valid, bus_g0.dout_valid};
    assign do_w   = {bus_g15.dout, bus_g1.dout, bus_g0.dout};
    assign busy_w = {bus_g15.busy, bus_g1.busy, bus_g0.busy};

    alu_serial_responder #(.RESP_GAP(0))  dut_g0  (.clk(clk), .rst(rst), .bus(bus_g0));
    alu_serial_responder #(.RESP_GAP(1))  dut_g1  (.clk(clk), .rst(rst), .bus(bus_g1));
    alu_serial_responder #(.RESP_GAP(15)) dut_g15 (.clk(clk), .rst(rst), .bus(bus_g15));

    int n_checks = 0;
    int n_fail   = 0;
    int gap_of [3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] frm(input logic t, input logic [7:0] d);
        return {t, d, ^{t, d}};
    endfunction

    // Reference model: plain signed/unsigned integer arithmetic on the decoded frames.
    function automatic logic [29:0] model(input logic [9:0] f0, input logic [9:0] f1,
                                          input logic [9:0] f2);
        int ua, ub, sa, sb, op, r;
        bit c, v, inv, perr, ferr;
        logic [15:0] res;
        logic [7:0]  st;
        ua = int'(f0[8:1]);
        ub = int'(f1[8:1]);
        op = int'(f2[8:1]);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0; v = 1'b0; inv = 1'b0; r = 0;
        case (op)
            1: begin r = sa + sb; c = (ua + ub > 255); v = (r > 127) || (r < -128); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: begin r = sa - sb; c = (ua < ub); v = (r > 127) || (r < -128); end
            6: r = sa * sb;
            default: inv = 1'b1;
        endcase
        perr = (^f0) | (^f1) | (^f2);
        ferr = f0[9] | f1[9] | !f2[9];
        res  = r[15:0];
        if (perr || ferr || inv) begin
            res = 16'h0000;
            st  = {1'b0, inv, ferr, perr, 4'b0000};
        end else begin
            st = {4'b0000, res[15], (res == 16'h0000), v, c};
        end
        return {frm(1'b1, st), frm(1'b0, res[15:8]), frm(1'b0, res[7:0])};
    endfunction

    task automatic send_bits(input logic [29:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            en_n  = 1'b0;
            din_b = w[29 - i];
        end
    endtask

    // Sends one command and collects the response of all three instances.
    task automatic run_cmd(input string tag, input logic [9:0] f0, input logic [9:0] f1,
                           input logic [9:0] f2, input logic [29:0] exp, input bit toggle);
        int first [3];
        int len [3];
        logic [29:0] st [3];
        bit done [3];
        send_bits({f0, f1, f2}, 30);
        @(posedge clk);
        #1;
        en_n  = 1'b1;
        din_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s busy_start g%0d", tag, gap_of[i]), 32'(busy_w[i]), 32'd1);
            first[i] = 0; len[i] = 0; st[i] = '0; done[i] = 1'b0;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (dv_w[i]) begin
                    if (len[i] == 0) first[i] = c;
                    st[i] = {st[i][28:0], do_w[i]};
                    len[i]++;
                end else if (len[i] > 0) begin
                    done[i] = 1'b1;
                end
            end
            if (toggle && c <= 29) begin
                en_n  = 1'($urandom);
                din_b = 1'($urandom);
            end else begin
                en_n  = 1'b1;
                din_b = 1'b0;
            end
            if (done[0] && done[1] && done[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s done g%0d", tag, gap_of[i]), 32'(done[i]), 32'd1);
            check($sformatf("%s stream g%0d", tag, gap_of[i]), 32'(st[i]), 32'(exp));
            check($sformatf("%s valid_len g%0d", tag, gap_of[i]), 32'(len[i]), 32'd30);
            check($sformatf("%s latency g%0d", tag, gap_of[i]), 32'(first[i]),
                  32'(gap_of[i] + 1));
            check($sformatf("%s busy_end g%0d", tag, gap_of[i]), 32'(busy_w[i]), 32'd0);
        end
        $display("cmd %s: f0=%03h f1=%03h f2=%03h expected=%08h got_g1=%08h",
                 tag, f0, f1, f2, exp, st[1]);
    endtask

    // types = {A, B, opcode} frame types; flip = parity-bit corruption per frame.
    task automatic dir_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [2:0] types,
                           input logic [2:0] flip, input logic [7:0] est,
                           input logic [15:0] eres, input bit toggle);
        logic [9:0] f0, f1, f2;
        logic [29:0] exp;
        f0  = frm(types[2], a)  ^ {9'b0, flip[2]};
        f1  = frm(types[1], b)  ^ {9'b0, flip[1]};
        f2  = frm(types[0], op) ^ {9'b0, flip[0]};
        exp = {frm(1'b1, est), frm(1'b0, eres[15:8]), frm(1'b0, eres[7:0])};
        run_cmd(tag, f0, f1, f2, exp, toggle);
    endtask

    initial begin
        logic [7:0] a, b, op;
        logic [9:0] f0, f1, f2;
        int kind, nbad;
        bit tg;

        gap_of[0] = 0; gap_of[1] = 1; gap_of[2] = 15;
        rst = 1'b1; en_n = 1'b1; din_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset dout g%0d", gap_of[i]), 32'(do_w[i]), 32'd0);
            check($sformatf("reset dv g%0d", gap_of[i]), 32'(dv_w[i]), 32'd0);
            check($sformatf("reset busy g%0d", gap_of[i]), 32'(busy_w[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        dir_cmd("add_ovf", 8'h7F, 8'h01, 8'h01, 3'b001, 3'b000, 8'h02, 16'h0080, 1'b0);
        dir_cmd("mul_neg", 8'hFE, 8'h03, 8'h06, 3'b001, 3'b000, 8'h08, 16'hFFFA, 1'b0);
        dir_cmd("sub_zero", 8'h05, 8'h05, 8'h05, 3'b001, 3'b000, 8'h04, 16'h0000, 1'b0);
        dir_cmd("par_err", 8'h01, 8'h01, 8'h01, 3'b001, 3'b100, 8'h10, 16'h0000, 1'b0);
        dir_cmd("bad_op", 8'h12, 8'h34, 8'hFF, 3'b001, 3'b000, 8'h40, 16'h0000, 1'b0);
        dir_cmd("type_err", 8'h01, 8'h02, 8'h01, 3'b000, 3'b000, 8'h20, 16'h0000, 1'b0);

        // Abort after 15 bits: nothing may come back and busy must stay low.
        send_bits({frm(1'b0, 8'hAA), frm(1'b0, 8'h55), frm(1'b1, 8'h01)}, 15);
        @(negedge clk);
        en_n = 1'b1;
        nbad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if ((|dv_w) || (|busy_w)) nbad++;
        end
        check("abort_quiet", 32'(nbad), 32'd0);
        $display("abort after 15 bits: active cycles=%0d", nbad);
        dir_cmd("and_after_abort", 8'hF0, 8'h3C, 8'h02, 3'b001, 3'b000, 8'h00, 16'h0030, 1'b0);

        dir_cmd("toggle_tx", 8'h7F, 8'h01, 8'h01, 3'b001, 3'b000, 8'h02, 16'h0080, 1'b1);

        // Reset while g1 is mid-response.
        send_bits({frm(1'b0, 8'h11), frm(1'b0, 8'h22), frm(1'b1, 8'h01)}, 30);
        @(posedge clk);
        #1;
        en_n = 1'b1;
        repeat (10) @(posedge clk);
        check("pre_rst_dv g1", 32'(dv_w[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midtx_rst dout g%0d", gap_of[i]), 32'(do_w[i]), 32'd0);
            check($sformatf("midtx_rst dv g%0d", gap_of[i]), 32'(dv_w[i]), 32'd0);
            check($sformatf("midtx_rst busy g%0d", gap_of[i]), 32'(busy_w[i]), 32'd0);
        end
        $display("reset mid-TX applied");
        @(negedge clk);
        rst = 1'b0;
        dir_cmd("after_rst", 8'h05, 8'h07, 8'h05, 3'b001, 3'b000, 8'h09, 16'hFFFE, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                op = 8'(kind + 1);
            end else if (kind == 6) begin
                op = 8'($urandom);
                if (op >= 8'h01 && op <= 8'h06) op = op | 8'h80;
            end else begin
                op = 8'($urandom_range(1, 6));
            end
            f0 = frm(1'b0, a);
            f1 = frm(1'b0, b);
            f2 = frm(1'b1, op);
            if (kind == 7) begin
                case ($urandom_range(0, 2))
                    0: f0[0] = ~f0[0];
                    1: f1[0] = ~f1[0];
                    default: f2[0] = ~f2[0];
                endcase
            end else if (kind == 8) begin
                case ($urandom_range(0, 2))
                    0: f0 = frm(1'b1, a);
                    1: f1 = frm(1'b1, b);
                    default: f2 = frm(1'b0, op);
                endcase
            end
            tg = ($urandom_range(0, 3) == 0);
            run_cmd($sformatf("rand%0d", n), f0, f1, f2, model(f0, f1, f2), tg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
